data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Memory-side responder for the core's load/store port. It serves the same traffic the pipeline's memory stage issues, using a valid/ready request channel and a valid/ready response channel. It models a word-addressed data RAM with byte-lane write strobes, a programmable access latency and an error response. Its purpose is to let the memory stage be stalled and tested against a realistic multi-cycle memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; legal values are powers of two, 16 to 65536.
LATENCY, 2, cycles from request acceptance to response valid; legal values are 1 to 15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
req_wstrb  input  4  byte-lane enables; bit i enables byte i (bits 8i+7:8i).
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  32  load data; 0 for stores and for errors.
rsp_error  output  1  request was misaligned or out of range.

Behaviour:
Reset (reset=0, asynchronous):
- State goes to IDLE.
- Outputs: req_ready=0 while reset is asserted, then 1 in IDLE; rsp_valid=0; rsp_rdata=0; rsp_error=0; latency counter=0.
- RAM contents are not cleared; they are retained across reset and undefined at power-up.

FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1, rsp_valid=0. A handshake (req_valid & req_ready at a rising edge) captures write, addr, wdata and wstrb into holding registers.
  - LATENCY=1: go to RESP at that edge, with the access performed at that edge.
  - LATENCY>1: load the counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready=0, rsp_valid=0. The counter decrements each edge. On the edge where the counter is 1, perform the access and go to RESP.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_error are stable until the handshake. On rsp_valid & rsp_ready, go to IDLE; req_ready rises in the following cycle. There is no request acceptance in the same cycle as the response handshake.
- rsp_ready high before rsp_valid has no effect.

Timing:
- Request accepted at edge k gives rsp_valid high in the cycle after edge k+LATENCY-1.
- Minimum throughput is one transaction per LATENCY+1 cycles.

Access and error rules (evaluated on the held request):
- offset = addr - BASE_ADDR, 32-bit unsigned wrap.
- error = (addr[1:0] != 0) or (offset[31:2] >= DEPTH_WORDS).
- Error: no RAM update, rsp_rdata=0, rsp_error=1.
- Legal load: rsp_rdata = RAM[offset[31:2]], rsp_error=0. req_wstrb is ignored on loads.
- Legal store: for each set wstrb bit, the corresponding byte is written at the access edge; other bytes are unchanged. rsp_rdata=0, rsp_error=0. wstrb=0 is a legal no-op store.

Boundary and reset cases:
- A load issued after a store's response handshake returns the stored data; there is no hazard window.
- Reset asserted in WAIT: the pending store is discarded and the RAM is unchanged.
- Reset asserted in RESP: the store has already committed; the response is dropped.
- Request inputs may change freely while req_ready=0; they are ignored.
- The highest legal word, offset = (DEPTH_WORDS-1)*4, is accepted. The next word up returns an error.

Test Plan:
- Reset then idle: with reset=0 -> rsp_valid=0, rsp_rdata=0, rsp_error=0; after release, req_ready=1 at the next edge.
- Latency and store/load (LATENCY=2):
  - Store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> rsp_valid 2 cycles after accept, rdata=0, error=0.
  - Load 0x10 -> rdata=0xDEADBEEF.
- Byte strobes: word 0x10 holds 0xDEADBEEF; store wdata 0x11223344, wstrb 4'b0101 -> a load returns 0xDE22BE44.
- Errors: load at 0x12 -> error=1, rdata=0. Store at DEPTH_WORDS*4 -> error=1, and a load of word 0 is unchanged. Load at (DEPTH_WORDS-1)*4 -> error=0.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and error stay constant and req_ready=0. Raise rsp_ready -> IDLE next cycle.
- Reset mid-transaction: a store to 0x20 accepted, then reset pulsed in WAIT -> after release, a load of 0x20 returns the pre-store value. With LATENCY=1, a store responds in the cycle after accept.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data RAM behind valid/ready request and response channels,
// with byte strobes, a fixed access latency and an error response for misaligned or out-of-range requests.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, access;
    logic        acc_write, acc_error;
    logic [31:0] acc_addr, acc_wdata, offset;
    logic [3:0]  acc_wstrb;
    logic [AW-1:0] acc_idx;

    assign accept = req_valid_i & ready_q;

    // With LATENCY=1 the access happens on the accept edge, so it must use the live request.
    assign acc_write = (state_q == IDLE) ? req_write_i : write_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
    assign acc_wstrb = (state_q == IDLE) ? req_wstrb_i : wstrb_q;

    assign offset    = acc_addr - BASE_ADDR;
    assign acc_error = (offset[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= DEPTH_WORDS);
    assign acc_idx   = offset[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
            end
            if (access) begin
                rdata_q <= (acc_write || acc_error) ? '0 : mem_q[acc_idx];
                error_q <= acc_error;
            end
        end
    end

    // RAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock_i) begin
        if (access && acc_write && !acc_error) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized checks of two responders (LATENCY=2 at base 0, LATENCY=1 at a
// nonzero base) against a word-array memory model.
module tb_data_memory_responder;
    localparam logic [31:0] BASE1 = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        sel = 1'b0;
    logic        rdy0, rdy1, v0, v1, e0, e1;
    logic [31:0] d0, d1;
    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;
    int          checks = 0, errors = 0;
    int          cyc = 0, last_acc = 0;
    logic [31:0] mdl0 [int];
    logic [31:0] mdl1 [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign cur_ready = sel ? rdy1 : rdy0;
    assign cur_valid = sel ? v1 : v0;
    assign cur_err   = sel ? e1 : e0;
    assign cur_rdata = sel ? d1 : d0;

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut0 (
        .clock_i(clk), .reset_ni(rst_n), .req_valid_i(req_valid & !sel), .req_ready_o(rdy0),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(v0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(d0), .rsp_error_o(e0));

    data_memory_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(BASE1)) u_dut1 (
        .clock_i(clk), .reset_ni(rst_n), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(v1), .rsp_ready_i(rsp_ready), .rsp_rdata_o(d1), .rsp_error_o(e1));

    function automatic logic [31:0] mget(input int idx);
        if (sel) return mdl1.exists(idx) ? mdl1[idx] : 32'hxxxx_xxxx;
        return mdl0.exists(idx) ? mdl0[idx] : 32'hxxxx_xxxx;
    endfunction

    task automatic mset(input int idx, input logic [31:0] v);
        if (sel) mdl1[idx] = v;
        else mdl0[idx] = v;
    endtask

    task automatic junk();
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold);
        int t = 0;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1; rsp_ready = 1'b0;
        while (cur_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL accept_timeout req_ready=%b required 1", cur_ready);
        end
        @(posedge clk);
        #1;
        last_acc  = cyc;
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
        junk();
    endtask

    task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic er);
        int n = 0;
        int lat = sel ? 1 : 2;
        bit bad_ready = 0;
        do begin
            @(negedge clk);
            n++;
            if (cur_valid !== 1'b1) begin
                if (cur_ready !== 1'b0) bad_ready = 1;
                req_valid = 1'($urandom);
                junk();
            end
        end while (cur_valid !== 1'b1 && n < 40);
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL latency got %0d cycles required %0d", n, lat);
        end
        checks++;
        if (bad_ready) begin
            errors++;
            $display("FAIL ready_in_wait got 1 required 0");
        end
        rd = cur_rdata;
        er = cur_err;
        req_valid = (hold == 0) ? 1'b0 : 1'($urandom);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({cur_valid, cur_ready, cur_err, cur_rdata} !== {1'b1, 1'b0, er, rd}) begin
                errors++;
                $display("FAIL rsp_stable got v=%b r=%b e=%b d=%h required v=1 r=0 e=%b d=%h",
                         cur_valid, cur_ready, cur_err, cur_rdata, er, rd);
            end
            junk();
            req_valid = (i == hold - 1) ? 1'b0 : 1'($urandom);
            if (i == hold - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({cur_valid, cur_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_handshake got v=%b r=%b required v=0 r=1", cur_valid, cur_ready);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, output logic [31:0] rd);
        logic [31:0] off, depth, old, expd;
        logic        er, exp_err;
        int          idx;
        off     = a - (sel ? BASE1 : 32'h0);
        depth   = sel ? 32'd16 : 32'd1024;
        exp_err = (a[1:0] != 2'b00) || ((off >> 2) >= depth);
        idx     = int'(off >> 2);
        old     = exp_err ? 32'h0 : mget(idx);
        issue(w, a, d, s, hold);
        finish_rsp(hold, rd, er);
        checks++;
        if (er !== exp_err) begin
            errors++;
            $display("FAIL rsp_error addr=%h got %b required %b", a, er, exp_err);
        end
        expd = (w || exp_err) ? 32'h0 : old;
        if (!$isunknown(expd)) begin
            checks++;
            if (rd !== expd) begin
                errors++;
                $display("FAIL rsp_rdata addr=%h got %h required %h", a, rd, expd);
            end
        end
        if (w && !exp_err) begin
            for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
            mset(idx, old);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rdy0, v0, e0, d0, rdy1, v1, e1, d1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got r=%b v=%b e=%b d=%h / r=%b v=%b e=%b d=%h required all 0",
                     rdy0, v0, e0, d0, rdy1, v1, e1, d1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, v0, v1} !== 4'b1100) begin
            errors++;
            $display("FAIL ready_after_reset got %b%b required 11", rdy0, rdy1);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        sel = 1'b0;
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_after_store got %h required deadbeef", rd);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        sel = 1'b0;
        do_txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 1, rd);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL strobe_merge got %h required de22be44", rd);
        end
        do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        sel = 1'b0;
        do_txn(1'b1, 32'h0, 32'h01020304, 4'hF, 0, rd);
        do_txn(1'b1, 32'hFFC, 32'hA1B2C3D4, 4'hF, 0, rd);
        do_txn(1'b0, 32'h12, 32'h0, 4'h0, 0, rd);
        do_txn(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd);
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
        do_txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0, rd);
        do_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd);
        do_txn(1'b1, 32'h13, 32'h55555555, 4'hF, 0, rd);
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        sel = 1'b0;
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
        do_txn(1'b1, 32'h14, 32'h89ABCDEF, 4'hF, 5, rd);
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        sel = 1'b0;
        do_txn(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 0, rd);
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v0, rdy0, d0, e0} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait got v=%b r=%b d=%h e=%b required 0", v0, rdy0, d0, e0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL store_discarded got %h required 0badf00d", rd);
        end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd;
        sel = 1'b0;
        issue(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (v0 !== 1'b1) begin
            errors++;
            $display("FAIL resp_before_reset got %b required 1", v0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v0, rdy0} !== 2'b00) begin
            errors++;
            $display("FAIL reset_in_resp got v=%b r=%b required 00", v0, rdy0);
        end
        mset(9, 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, rd);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL store_committed got %h required cafef00d", rd);
        end
    endtask

    task automatic test_latency1();
        logic [31:0] rd;
        sel = 1'b1;
        do_txn(1'b1, BASE1, 32'h76543210, 4'hF, 0, rd);
        do_txn(1'b0, BASE1, 32'h0, 4'h0, 2, rd);
        do_txn(1'b1, BASE1 + 32'h3C, 32'hFEEDFACE, 4'hF, 0, rd);
        do_txn(1'b0, BASE1 + 32'h3C, 32'h0, 4'h0, 0, rd);
        checks++;
        if (rd !== 32'hFEEDFACE) begin
            errors++;
            $display("FAIL top_word_load got %h required feedface", rd);
        end
        do_txn(1'b0, BASE1 + 32'h40, 32'h0, 4'h0, 0, rd);
        do_txn(1'b1, BASE1 - 32'h4, 32'h1, 4'hF, 1, rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int prev;
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k);
            do_txn(1'b0, sel ? BASE1 : 32'h0, 32'h0, 4'h0, 0, rd);
            for (int i = 0; i < 4; i++) begin
                prev = last_acc;
                do_txn(1'($urandom), (sel ? BASE1 : 32'h0) + 32'(4 * i), $urandom, 4'hF, 0, rd);
                checks++;
                if (last_acc - prev !== (sel ? 2 : 3)) begin
                    errors++;
                    $display("FAIL throughput got %0d cycles required %0d", last_acc - prev, sel ? 2 : 3);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, base;
        int idx, depth;
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k);
            for (int i = 0; i < 16; i++) do_txn(1'b1, (sel ? BASE1 : 32'h0) + 32'(4 * i), $urandom, 4'hF, 0, rd);
        end
        sel = 1'b0;
        for (int i = 1016; i < 1024; i++) do_txn(1'b1, 32'(4 * i), $urandom, 4'hF, 0, rd);
        for (int n = 0; n < 250; n++) begin
            sel   = 1'($urandom);
            base  = sel ? BASE1 : 32'h0;
            depth = sel ? 16 : 1024;
            idx   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : depth - 1 - $urandom_range(0, 7);
            a     = base + 32'(4 * idx);
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = base + 32'(4 * (depth + $urandom_range(0, 7)));
                2: a = $urandom;
                default: ;
            endcase
            do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_strobes();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_reset_resp();
        test_latency1();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
